// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: checks and issues one data-memory access at a time, returns extended load data
module lsu #(
    parameter int MEM_BYTES = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        memRW_o,
    output logic [1:0]  dataSec_o,
    output logic [31:0] dataW_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [2:0]  size;
    logic [32:0] last_byte;
    logic        illegal;
    logic        sext;
    logic [31:0] load_val;

    assign req_ready_o = (state == IDLE) && !rst;

    // The last touched byte is formed at 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        case (funct3_i[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        last_byte = {1'b0, addr_i} + {30'd0, size} - 33'd1;
        illegal   = (funct3_i[1:0] == 2'b11)
                  || (funct3_i == 3'b110)
                  || (is_store_i && funct3_i[2])
                  || ((funct3_i[1:0] == 2'b01) && addr_i[0])
                  || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00))
                  || (last_byte > 33'(MEM_BYTES - 1));
    end

    always_comb begin
        sext = !funct3_q[2];
        case (funct3_q[1:0])
            2'b00:   load_val = {{24{sext & data_i[31]}}, data_i[31:24]};
            2'b01:   load_val = {{16{sext & data_i[31]}}, data_i[31:16]};
            default: load_val = data_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            rsp_valid_o <= 1'b0;
            rdata_o     <= 32'd0;
            err_o       <= 1'b0;
            memRW_o     <= 1'b0;
            dataSec_o   <= 2'b11;
            dataW_o     <= 32'd0;
            addr_o      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        is_store_q <= is_store_i;
                        funct3_q   <= funct3_i;
                        if (illegal) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            err_o       <= 1'b1;
                            rdata_o     <= 32'd0;
                        end else begin
                            state     <= ACCESS;
                            addr_o    <= addr_i;
                            dataSec_o <= funct3_i[1:0];
                            memRW_o   <= is_store_i;
                            dataW_o   <= wdata_i;
                        end
                    end
                end
                ACCESS: begin
                    memRW_o   <= 1'b0;
                    dataSec_o <= 2'b11;
                    if (is_store_q) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        err_o       <= 1'b0;
                        rdata_o     <= 32'd0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata_o     <= load_val;
                    err_o       <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        err_o       <= 1'b0;
                        rdata_o     <= 32'd0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed bench for lsu against a transaction-level reference model
module tb_lsu;

    localparam int MB = 21;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rdata;
    logic        err;
    logic        mem_rw;
    logic [1:0]  data_sec;
    logic [31:0] data_w;
    logic [31:0] mem_addr;
    logic [31:0] data_i = 32'd0;

    lsu #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rdata_o(rdata), .err_o(err),
        .memRW_o(mem_rw), .dataSec_o(data_sec), .dataW_o(data_w), .addr_o(mem_addr),
        .data_i(data_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Data memory seen by the DUT: registered read, big-endian byte lanes.
    logic [7:0] dmem [0:MB-1];

    function automatic logic [7:0] rd(input longint i);
        return (i < MB) ? dmem[int'(i)] : 8'h00;
    endfunction

    always @(posedge clk) begin
        longint a;
        int sz;
        a = longint'({32'd0, mem_addr});
        if (mem_rw) begin
            sz = (data_sec == 2'b00) ? 1 : (data_sec == 2'b01) ? 2 : 4;
            for (int i = 0; i < sz; i++)
                if (a + i < MB) dmem[int'(a) + i] = 8'(data_w >> (8 * (sz - 1 - i)));
        end
        data_i <= {rd(a), rd(a + 1), rd(a + 2), rd(a + 3)};
    end

    // Reference model: one outstanding transaction, timing from edge numbers.
    logic [7:0]  ref_mem [0:MB-1];
    int          n = 0;
    bit          busy = 0;
    int          acc_edge, rsp_edge, m_sz;
    int          acc_count = 0;
    logic        m_store, m_err;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always @(posedge clk) begin
        longint v;
        bit ok;
        n = n + 1;
        if (rst) begin
            busy = 0;
        end else begin
            if (busy && m_store && !m_err && n == acc_edge + 1)
                for (int i = 0; i < m_sz; i++)
                    ref_mem[int'(m_addr) + i] = 8'(m_wdata >> (8 * (m_sz - 1 - i)));
            if (busy) begin
                if (n > rsp_edge && rsp_ready) busy = 0;
            end else if (req_valid) begin
                acc_count++;
                busy = 1;
                m_store = is_store; m_f3 = funct3; m_addr = addr; m_wdata = wdata;
                m_sz = (funct3 == 0 || funct3 == 4) ? 1 : (funct3 == 1 || funct3 == 5) ? 2 : 4;
                ok = (funct3 == 0 || funct3 == 1 || funct3 == 2 || funct3 == 4 || funct3 == 5)
                     && !(is_store && funct3 >= 4)
                     && (addr % m_sz == 0)
                     && (longint'({32'd0, addr}) + m_sz <= MB);
                m_err = !ok;
                m_rdata = 32'd0;
                if (!ok) begin
                    acc_edge = -10; rsp_edge = n;
                end else if (is_store) begin
                    acc_edge = n; rsp_edge = n + 1;
                end else begin
                    acc_edge = n; rsp_edge = n + 2;
                    v = 0;
                    for (int i = 0; i < m_sz; i++) v = (v << 8) | longint'(ref_mem[int'(addr) + i]);
                    if (funct3 < 4 && m_sz < 4 && v[8 * m_sz - 1]) v = v - (longint'(1) << (8 * m_sz));
                    m_rdata = v[31:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        bit active, exp_rsp;
        if (!rst && chk_on) begin
            active  = busy && !m_err && n == acc_edge;
            exp_rsp = busy && n >= rsp_edge;
            chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp});
            if (exp_rsp) begin
                chk("rdata", rdata, m_rdata);
                chk("err", {31'd0, err}, {31'd0, m_err});
            end
            chk("memRW", {31'd0, mem_rw}, {31'd0, active & m_store});
            chk("dataSec", {30'd0, data_sec}, active ? {30'd0, m_f3[1:0]} : 32'd3);
            if (active) begin
                chk("addr_o", mem_addr, m_addr);
                chk("dataW", data_w, m_wdata);
            end
        end
    end

    logic [31:0] last_rdata;
    logic        last_err;

    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int stall, input bit junk);
        int start;
        bit got;
        @(negedge clk);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rsp_ready = 1'b0;
        start = acc_count;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (acc_count != start) begin got = 1; break; end
        end
        req_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        last_rdata = rdata;
        last_err   = err;
        for (int k = 0; k < stall; k++) begin
            if (junk) begin
                req_valid = 1'b1; is_store = 1'($urandom); funct3 = 3'($urandom);
                addr = 32'($urandom_range(0, 20)); wdata = $urandom;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MB; i++) begin
            dmem[i] = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        dmem[4] = 8'h12; dmem[5] = 8'h34; dmem[6] = 8'h56; dmem[7] = 8'h78;
        dmem[9] = 8'h80; dmem[10] = 8'h80; dmem[11] = 8'h01;
        for (int i = 0; i < MB; i++) ref_mem[i] = dmem[i];

        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_memRW", {31'd0, mem_rw}, 32'd0);
        chk("rst_dataSec", {30'd0, data_sec}, 32'd3);
        chk("rst_dataW", data_w, 32'd0);
        chk("rst_addr_o", mem_addr, 32'd0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        chk_on = 1;

        txn(1'b0, 3'b010, 32'd4, 32'd0, 0, 0);
        chk("lw4", last_rdata, 32'h12345678);
        txn(1'b0, 3'b000, 32'd9, 32'd0, 0, 0);
        chk("lb9", last_rdata, 32'hFFFFFF80);
        txn(1'b0, 3'b100, 32'd9, 32'd0, 0, 0);
        chk("lbu9", last_rdata, 32'h00000080);
        txn(1'b0, 3'b001, 32'd10, 32'd0, 0, 0);
        chk("lh10", last_rdata, 32'hFFFF8001);
        txn(1'b0, 3'b101, 32'd10, 32'd0, 0, 0);
        chk("lhu10", last_rdata, 32'h00008001);
        txn(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 0, 0);
        chk("sw8_rdata", last_rdata, 32'd0);
        txn(1'b0, 3'b010, 32'd8, 32'd0, 5, 1);
        chk("lw8_backpressure", last_rdata, 32'hDEADBEEF);

        txn(1'b0, 3'b001, 32'd3, 32'd0, 0, 0);
        chk("err_lh3", {31'd0, last_err}, 32'd1);
        txn(1'b1, 3'b010, 32'd2, 32'h5, 0, 0);
        chk("err_sw2", {31'd0, last_err}, 32'd1);
        txn(1'b0, 3'b010, 32'd18, 32'd0, 0, 0);
        chk("err_lw18", {31'd0, last_err}, 32'd1);
        txn(1'b0, 3'b011, 32'd0, 32'd0, 0, 0);
        chk("err_f3_011", {31'd0, last_err}, 32'd1);
        txn(1'b1, 3'b100, 32'd0, 32'h7, 0, 0);
        chk("err_sb_f3_100", {31'd0, last_err}, 32'd1);
        txn(1'b0, 3'b010, 32'hFFFFFFFC, 32'd0, 0, 0);
        chk("err_wrap", {31'd0, last_err}, 32'd1);

        // Reset in the middle of a store's memory cycle must cancel the write.
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'd8; wdata = 32'h11111111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("arst_pre_memRW", {31'd0, mem_rw}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_memRW", {31'd0, mem_rw}, 32'd0);
        chk("arst_dataSec", {30'd0, data_sec}, 32'd3);
        chk("arst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_addr_o", mem_addr, 32'd0);
        chk("arst_dataW", data_w, 32'd0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        txn(1'b0, 3'b010, 32'd8, 32'd0, 0, 0);
        chk("lw8_after_rst", last_rdata, 32'hDEADBEEF);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else a = 32'($urandom_range(0, 24));
            txn(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
